// File: rtl/adas_brake_controller.sv
// ADAS automatic emergency braking controller.
// Confirms an obstacle (camera AND radar) for CONFIRM_CYCLES consecutive
// edges before braking, holds braking HOLD_CYCLES after the obstacle clears,
// and drops to FAULT on any ADAS error. The driver pedal always reaches the
// actuator combinationally, independent of the FSM.
// Build option: define ADAS_FAULT_LATCH_EN to make FAULT sticky until reset.
module adas_brake_controller #(
  parameter int CONFIRM_CYCLES = 4,  // legal 2..255
  parameter int HOLD_CYCLES    = 8   // legal 1..255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       driver_break,
  input  logic       camera,
  input  logic       radar,
  input  logic       adas_error,
  output logic       vehicle_break,
  output logic       auto_break,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIRM = 3'd1,
    BRAKE   = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // Counter compare points; both fit in 8 bits for every legal parameter,
  // so the counter reaches its exit value before it could ever wrap.
  localparam logic [7:0] CONFIRM_LAST = 8'(CONFIRM_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES);

  state_t     state_q;
  logic [7:0] count_q;
  logic       obstacle;

  assign obstacle = camera & radar;

  // FSM: state, counter and the registered status flags move together so
  // auto_break/fault always reflect the state register exactly.
  // NOTE: every sequential assignment is non-blocking so all registers in
  // this block update from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      auto_break <= 1'b0;
      fault      <= 1'b0;
    end else if (adas_error) begin
      // Error outranks every other transition and always clears the counter.
      state_q    <= FAULT;
      count_q    <= 8'd0;
      auto_break <= 1'b0;
      fault      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (obstacle) begin
            state_q <= CONFIRM;
            count_q <= 8'd1;
          end
        end
        CONFIRM: begin
          if (!obstacle) begin
            state_q <= IDLE;
            count_q <= 8'd0;
          end else if (count_q == CONFIRM_LAST) begin
            state_q    <= BRAKE;
            count_q    <= 8'd0;
            auto_break <= 1'b1;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        BRAKE: begin
          if (!obstacle) begin
            state_q <= HOLD;
            count_q <= 8'd1;
          end
        end
        HOLD: begin
          if (obstacle) begin
            // Obstacle back during hold: resume braking without reconfirming.
            state_q <= BRAKE;
            count_q <= 8'd0;
          end else if (count_q == HOLD_LAST) begin
            state_q    <= IDLE;
            count_q    <= 8'd0;
            auto_break <= 1'b0;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        FAULT: begin
`ifdef ADAS_FAULT_LATCH_EN
          // Sticky fault: only reset leaves this state.
          state_q <= FAULT;
`else
          // Error has cleared this edge: recover to IDLE.
          state_q <= IDLE;
          fault   <= 1'b0;
`endif
        end
        default: begin
          // Unused encodings 5..7 recover to IDLE.
          state_q    <= IDLE;
          count_q    <= 8'd0;
          auto_break <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

  // Driver pedal has zero-latency authority in every state, even in reset.
  assign vehicle_break = driver_break | auto_break;

  assign state = state_q;

endmodule
